sdram_bist_gen: RTL and testbench

Synthesizable traffic generator and checker driving the user port of `fpga_sdram_top` (write and read channels) from the upstream side. On `start` it writes NUM_BURSTS bursts of BURST_LEN words to consecutive addresses, reading back and comparing each burst before the next. It reports progress, mismatch count and pass/fail. This lets board bring-up run without the simulation testbench.

---
 rtl/sdram_bist_gen.sv | 145 ++++++++++++++
 tb/tb_sdram_bist_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_bist_gen.sv
// sdram_bist_gen: write/read-compare BIST for the SDRAM user port; define SDRAM_BIST_PRBS_EN for an LFSR data pattern
module sdram_bist_gen #(
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 16,
    parameter int BURST_LEN  = 2,
    parameter int NUM_BURSTS = 1024,
    parameter int RD_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_done,
    input  logic              start,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_avalid,
    input  logic              rd_aready,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_cnt,
    output logic [15:0]       burst_cnt
);
    typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_DATA, NEXT, DONE} state_t;
    localparam int WD_W = $clog2(RD_TIMEOUT + 1);
`ifdef SDRAM_BIST_PRBS_EN
    localparam int PW = 16;
    localparam logic [PW-1:0] SEED = 16'hACE1;
    function automatic logic [PW-1:0] adv(input logic [PW-1:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[PW-1:1]};
    endfunction
`else
    localparam int PW = DATA_W;
    localparam logic [PW-1:0] SEED = '0;
    function automatic logic [PW-1:0] adv(input logic [PW-1:0] l);
        return l + PW'(1);
    endfunction
`endif
    function automatic logic [DATA_W-1:0] expand(input logic [PW-1:0] p);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) r[i] = p[i % PW];
        return r;
    endfunction

    state_t state, next;
    logic [PW-1:0] wpat, epat;
    logic [3:0] cnt;
    logic [WD_W-1:0] wd;
    logic [ADDR_W-1:0] addr;
    logic wr_hs, ra_hs, rd_hs, hs, last, active, expire, go;
    logic wr_valid_d, rd_avalid_d, rd_ready_d, busy_d, done_d, pass_d;

    assign wr_hs   = wr_valid & wr_ready;
    assign ra_hs   = rd_avalid & rd_aready;
    assign rd_hs   = rd_ready & rd_valid;
    assign hs      = wr_hs | ra_hs | rd_hs;
    assign last    = cnt == 4'(BURST_LEN - 1);
    assign active  = state inside {WR, RD_REQ, RD_DATA};
    assign expire  = active & ~hs & (wd == WD_W'(RD_TIMEOUT - 1));
    assign go      = (state == IDLE || state == DONE) & start & init_done;
    assign wr_data = expand(wpat);
    assign wr_addr = addr;
    assign rd_addr = addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_valid  <= 1'b0;
            rd_avalid <= 1'b0;
            rd_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state     <= next;
            wr_valid  <= wr_valid_d;
            rd_avalid <= rd_avalid_d;
            rd_ready  <= rd_ready_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE, DONE: next = go ? WR : state;
            WR:         next = (wr_hs & last) ? RD_REQ : WR;
            RD_REQ:     next = ra_hs ? RD_DATA : RD_REQ;
            RD_DATA:    next = (rd_hs & last) ? NEXT : RD_DATA;
            NEXT:       next = (burst_cnt == 16'(NUM_BURSTS - 1)) ? DONE : WR;
            default:    next = IDLE;
        endcase
        next = expire ? DONE : next;
    end

    always_comb begin
        wr_valid_d  = next == WR;
        rd_avalid_d = next == RD_REQ;
        rd_ready_d  = next == RD_DATA;
        busy_d      = next inside {WR, RD_REQ, RD_DATA, NEXT};
        done_d      = next == DONE;
        pass_d      = (next == DONE) & ~expire & ~timeout & (err_cnt == 16'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wpat      <= '0;
            epat      <= '0;
            cnt       <= '0;
            wd        <= '0;
            addr      <= '0;
            err_cnt   <= '0;
            burst_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            wd  <= (state != next || hs || !active) ? '0 : wd + WD_W'(1);
            cnt <= (state != next) ? 4'd0 : (wr_hs | rd_hs) ? cnt + 4'd1 : cnt;
            if (go) begin
                wpat      <= SEED;
                epat      <= SEED;
                addr      <= '0;
                err_cnt   <= '0;
                burst_cnt <= '0;
                timeout   <= 1'b0;
            end else begin
                if (wr_hs) wpat <= adv(wpat);
                if (rd_hs) epat <= adv(epat);
                if (rd_hs && rd_data != expand(epat) && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                if (state == NEXT) begin
                    burst_cnt <= burst_cnt + 16'd1;
                    addr      <= addr + ADDR_W'(BURST_LEN);
                end
                if (expire) timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sdram_bist_gen.sv
// tb_sdram_bist_gen: directed bench for sdram_bist_gen with a small wrapping memory model
module tb_sdram_bist_gen;
    localparam int AW = 4, DW = 16, BL = 2, NB = 10, TO = 15;

    logic clk = 0, rst_n = 0, init_done = 0, start = 0;
    logic wr_ready = 1, rd_aready = 1, rd_en = 1, inj = 0;
    logic [DW-1:0] wr_data, rd_data;
    logic [AW-1:0] wr_addr, rd_addr;
    logic wr_valid, rd_avalid, rd_valid, rd_ready, busy, done, pass, timeout;
    logic [15:0] err_cnt, burst_cnt;

    int checks = 0, fails = 0;
    int n, bad;
    logic stable;

    logic [15:0] mem [16];
    logic [15:0] wlog [64];
    logic [AW-1:0] alog [16];
    logic [AW-1:0] rptr = '0;
    int rleft = 0, woff = 0, nw = 0, nb = 0, rcnt = 0;

    logic [31:0] flags, dz, az;
    assign flags = {25'd0, wr_valid, rd_avalid, rd_ready, busy, done, pass, timeout};
    assign dz    = {wr_data, err_cnt};
    assign az    = {8'd0, wr_addr, rd_addr, burst_cnt};

    sdram_bist_gen #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .NUM_BURSTS(NB), .RD_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done), .start(start),
        .wr_data(wr_data), .wr_addr(wr_addr), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_addr(rd_addr), .rd_avalid(rd_avalid), .rd_aready(rd_aready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_cnt(err_cnt), .burst_cnt(burst_cnt)
    );

    always #5 clk = ~clk;

    assign rd_valid = rd_en && rleft != 0;
    assign rd_data  = mem[rptr] ^ {15'd0, inj && rcnt == 3};

    always @(posedge clk) begin
        if (!rst_n) begin
            woff  <= 0;
            rleft <= 0;
            rptr  <= '0;
        end else begin
            if (start && init_done && !busy) begin
                nw    <= 0;
                nb    <= 0;
                rcnt  <= 0;
                woff  <= 0;
                rleft <= 0;
            end
            if (wr_valid && wr_ready) begin
                mem[wr_addr + AW'(woff)] <= wr_data;
                wlog[nw] <= wr_data;
                nw <= nw + 1;
                if (woff == 0) begin
                    alog[nb] <= wr_addr;
                    nb <= nb + 1;
                end
                woff <= (woff == BL - 1) ? 0 : woff + 1;
            end
            if (rd_avalid && rd_aready) begin
                rptr  <= rd_addr;
                rleft <= BL;
            end else if (rd_valid && rd_ready) begin
                rptr  <= rptr + 1'b1;
                rleft <= rleft - 1;
                rcnt  <= rcnt + 1;
            end
        end
    end

    function automatic logic [15:0] exp_word(input int i);
`ifdef SDRAM_BIST_PRBS_EN
        logic [15:0] l = 16'hACE1;
        repeat (i) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        return l;
`else
        return 16'(i);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
    endtask

    task automatic run_to_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 400) begin
            step();
            cyc++;
        end
        chk("done_reached", done, 1);
    endtask

    initial begin
        repeat (3) step();
        chk("reset_flags", flags, 0);
        chk("reset_data", dz, 0);
        chk("reset_addr_cnt", az, 0);

        @(negedge clk) rst_n = 1;
        pulse_start();
        step();
        chk("start_ignored_no_init", flags, 0);
        init_done = 1;

        pulse_start();
        chk("start_latency_wr_valid", wr_valid, 1);
        chk("first_word", wr_data, exp_word(0));
        chk("first_addr", wr_addr, 0);
        run_to_done(n);
        chk("basic_cycles", n, NB * (BL + 1 + BL + 1));
        chk("basic_pass", pass, 1);
        chk("basic_err_cnt", err_cnt, 0);
        chk("basic_burst_cnt", burst_cnt, NB);
        chk("basic_timeout", timeout, 0);
        chk("basic_busy", busy, 0);
        chk("basic_words", nw, NB * BL);
        bad = 0;
        for (int i = 0; i < NB * BL; i++) if (wlog[i] !== exp_word(i)) bad++;
        chk("basic_write_sequence", bad, 0);
        bad = 0;
        for (int a = 0; a < 16; a++) if (mem[a] !== exp_word(a < 4 ? a + 16 : a)) bad++;
        chk("basic_mem_contents", bad, 0);
        chk("addr_burst2", alog[1], 2);
        chk("addr_burst8", alog[7], 14);
        chk("addr_wrap_burst9", alog[8], 0);
        chk("addr_burst10", alog[9], 2);

        pulse_start();
        step();
        chk("bp_second_word", wr_data, exp_word(1));
        wr_ready = 0;
        stable = 1;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) start = 1;
            step();
            start = 0;
            stable &= wr_valid && wr_data === exp_word(1) && wr_addr === '0 && busy;
        end
        chk("bp_hold_stable", stable, 1);
        wr_ready = 1;
        run_to_done(n);
        chk("bp_pass", pass, 1);
        chk("bp_words", nw, NB * BL);
        bad = 0;
        for (int i = 0; i < NB * BL; i++) if (wlog[i] !== exp_word(i)) bad++;
        chk("bp_no_skip", bad, 0);

        inj = 1;
        pulse_start();
        n = 0;
        while (!(rd_valid && rd_ready && rcnt == 3) && n < 200) begin
            step();
            n++;
        end
        chk("inj_word_reached", n < 200, 1);
        chk("inj_err_before", err_cnt, 0);
        step();
        chk("inj_err_one_cycle_later", err_cnt, 1);
        run_to_done(n);
        chk("inj_err_cnt", err_cnt, 1);
        chk("inj_pass", pass, 0);
        chk("inj_burst_cnt", burst_cnt, NB);
        inj = 0;

        rd_en = 0;
        pulse_start();
        n = 0;
        while (!rd_ready && n < 50) begin
            step();
            n++;
        end
        chk("to_rd_data_entered", rd_ready, 1);
        n = 0;
        while (rd_ready && n < 40) begin
            step();
            n++;
        end
        chk("to_within_17", n >= 14 && n <= 17, 1);
        chk("to_flags", flags, 32'h0000_0005);
        chk("to_burst_cnt", burst_cnt, 0);

        rd_en = 1;
        pulse_start();
        n = 0;
        while (!rd_ready && n < 50) begin
            step();
            n++;
        end
        chk("rst_rd_data_entered", rd_ready, 1);
        @(negedge clk) rst_n = 0;
        step();
        chk("rst_mid_flags", flags, 0);
        chk("rst_mid_data", dz, 0);
        chk("rst_mid_addr_cnt", az, 0);
        @(negedge clk) rst_n = 1;
        pulse_start();
        chk("restart_first_word", wr_data, exp_word(0));
        run_to_done(n);
        chk("restart_pass", pass, 1);
        chk("restart_burst_cnt", burst_cnt, NB);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
